periodogram_frame_ctrl: RTL
===========================

Name: periodogram_frame_ctrl

Overview:
Frame-level sequencer for the periodogram_squared datapath in the MFCC front end. On a start pulse it reads the one-sided spectrum (bins 0..NF/2) of a completed FFT frame from the FFT result RAM and streams it into the periodogram unit. It collects the power results into a small credit-managed skid FIFO and forwards them to the mel filterbank under a valid/ready handshake. It also accumulates total frame energy and reports frame completion.

Parameters:
NF, 512, FFT frame length; NBINS = NF/2+1 = 257 bins processed.
ADDR_W, 9, FFT RAM address and bin index width (>= clog2(NF)).
CREDITS, 4, max results in flight plus queued (skid FIFO depth), power of two.
ENERGY_W, 48, frame energy accumulator width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  frame start pulse; honoured only when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, frame complete
fft_rd_en  out  1  FFT RAM read strobe
fft_rd_addr  out  ADDR_W  FFT RAM bin address
fft_rd_real  in  16  signed, valid the cycle after fft_rd_en
fft_rd_imag  in  16  signed, valid the cycle after fft_rd_en
pg_sample_real  out  16  to periodogram sample_in_real (= fft_rd_real)
pg_sample_imag  out  16  to periodogram sample_in_imag (= fft_rd_imag)
pg_sample_valid  out  1  to periodogram sample_valid (fft_rd_en delayed 1)
pg_out  in  32  signed periodogram result
pg_valid  in  1  periodogram result strobe (arbitrary fixed latency)
pow_data  out  32  power value to filterbank
pow_bin  out  ADDR_W  bin index of pow_data
pow_last  out  1  high with bin NBINS-1
pow_valid  out  1  FIFO not empty
pow_ready  in  1  filterbank accept
frame_energy  out  ENERGY_W  sum of all popped pow_data, held after done
err  out  1  sticky: pg_valid with no result outstanding; cleared only by rst

Behaviour:
- Reset: state IDLE. busy, done, fft_rd_en, pg_sample_valid, pow_valid, pow_last, err = 0; fft_rd_addr, pow_bin, frame_energy = 0. FIFO flushed; issue, outstanding and output counters zeroed.
- States: IDLE -> RUN on start; RUN -> DRAIN when NBINS reads issued; DRAIN -> DONE when outstanding==0, FIFO empty and NBINS pops done; DONE -> IDLE after 1 cycle (done=1 there).
- start in IDLE: next cycle RUN, busy=1, frame_energy cleared, counters cleared. start outside IDLE is ignored.
- Issue rule (RUN): fft_rd_en=1 iff rd_idx < NBINS and outstanding + fifo_count < CREDITS, both evaluated on registered values of the current cycle. fft_rd_addr = rd_idx; rd_idx increments on each issue. Bins are issued in order 0..NBINS-1.
- pg_sample_valid is fft_rd_en registered. pg_sample_real/imag pass RAM data through combinationally.
- outstanding: +1 on fft_rd_en, -1 on pg_valid; both in one cycle leaves it unchanged.
- pg_valid pushes pg_out into the FIFO. The credit rule guarantees the FIFO is never full on a push. If pg_valid arrives with outstanding==0, err=1 and the data is dropped.
- Pop: pow_valid && pow_ready. On pop, out_idx increments and frame_energy += pow_data, zero-extended, with no overflow possible at the defaults. pow_bin = out_idx; pow_last = (out_idx == NBINS-1) && pow_valid.
- Push and pop in the same cycle: fifo_count unchanged, data order preserved. A push into an empty FIFO is visible on pow_valid the next cycle.
- Unbounded backpressure: issue stalls and nothing is lost.
- rst mid-frame: abort immediately to IDLE. No done pulse. Frame discarded.

Test Plan:
- RAM real=4096, imag=0 all bins, pow_ready=1 -> 257 outputs of 512 with bins 0..256, pow_last only on bin 256, frame_energy=131584, single done pulse, busy low after.
- RAM real=k, imag=-k -> pow_bin 128 = 1, bin 256 = 4, bin 10 = 0. Output order matches bin order.
- pow_ready low for 20 cycles from bin 50 -> issues never exceed pops+4, fft_rd_en stops, all 257 results delivered in order, energy unchanged vs. no-stall run.
- start asserted again at bin 100 -> ignored, exactly 257 outputs and one done. A start in the done cycle is also ignored; a start 1 cycle later begins a new frame with energy cleared.
- rst at bin 80 then a new start -> no done from the aborted frame. New frame yields 257 outputs from bin 0; err=0.
- pg_valid forced while IDLE -> err=1 and stays 1 through a following frame, which still completes correctly; rst clears err.

Source files
------------

// File: rtl/periodogram_frame_ctrl.sv
// rtl/periodogram_frame_ctrl.sv - frame sequencer feeding periodogram_squared and the mel filterbank
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, busy, done              frame start pulse, in-frame flag, one-cycle completion pulse
//   fft_rd_en, fft_rd_addr         FFT result RAM read strobe and bin address
//   fft_rd_real, fft_rd_imag       RAM read data, valid the cycle after fft_rd_en
//   pg_sample_real/imag/valid      samples towards the periodogram unit
//   pg_out, pg_valid               periodogram results (fixed but unknown latency)
//   pow_data, pow_bin, pow_last    power stream to the filterbank
//   pow_valid, pow_ready           handshake of the power stream
//   frame_energy                   sum of all delivered power values of the frame
//   err                            sticky: result strobe with nothing outstanding
module periodogram_frame_ctrl #(
  parameter int NF       = 512,
  parameter int ADDR_W   = 9,
  parameter int CREDITS  = 4,
  parameter int ENERGY_W = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       fft_rd_en,
  output logic [ADDR_W-1:0]          fft_rd_addr,
  input  logic signed [15:0]         fft_rd_real,
  input  logic signed [15:0]         fft_rd_imag,
  output logic signed [15:0]         pg_sample_real,
  output logic signed [15:0]         pg_sample_imag,
  output logic                       pg_sample_valid,
  input  logic signed [31:0]         pg_out,
  input  logic                       pg_valid,
  output logic [31:0]                pow_data,
  output logic [ADDR_W-1:0]          pow_bin,
  output logic                       pow_last,
  output logic                       pow_valid,
  input  logic                       pow_ready,
  output logic [ENERGY_W-1:0]        frame_energy,
  output logic                       err
);

  localparam int NBINS = NF / 2 + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int OCC_W = $clog2(CREDITS) + 1;

  localparam logic [CNT_W-1:0] NBINS_C   = CNT_W'(NBINS);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(NBINS - 1);
  localparam logic [OCC_W:0]   CREDITS_C = (OCC_W + 1)'(CREDITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  out_idx;
  logic [OCC_W-1:0]  outstanding;
  logic [OCC_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       fifo_mem [CREDITS];

  logic issue;
  logic push;
  logic pop;

  // A read is only issued when a FIFO slot is guaranteed for its result:
  // every read in flight plus every queued result holds one credit.
  assign issue = (state == S_RUN) && (rd_idx < NBINS_C) &&
                 (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS_C);
  // A result with nothing outstanding is a protocol error and is dropped.
  assign push  = pg_valid && (outstanding != '0);
  assign pop   = pow_valid && pow_ready;

  assign fft_rd_en      = issue;
  assign fft_rd_addr    = rd_idx[ADDR_W-1:0];
  assign pg_sample_real = fft_rd_real;
  assign pg_sample_imag = fft_rd_imag;

  assign pow_valid = (fifo_count != '0);
  assign pow_data  = fifo_mem[rd_ptr];
  assign pow_bin   = out_idx[ADDR_W-1:0];
  assign pow_last  = pow_valid && (out_idx == LAST_C);

  // Result skid FIFO; never full on a push thanks to the credit rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pg_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_idx          <= '0;
      out_idx         <= '0;
      outstanding     <= '0;
      frame_energy    <= '0;
      err             <= 1'b0;
      pg_sample_valid <= 1'b0;
    end else begin
      done            <= 1'b0;
      pg_sample_valid <= issue;

      if (pg_valid && (outstanding == '0)) err <= 1'b1;

      unique case ({issue, push})
        2'b10:   outstanding <= outstanding + OCC_W'(1);
        2'b01:   outstanding <= outstanding - OCC_W'(1);
        default: ;
      endcase

      if (pop) begin
        out_idx      <= out_idx + CNT_W'(1);
        frame_energy <= frame_energy + ENERGY_W'(pow_data);
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            rd_idx       <= '0;
            out_idx      <= '0;
            frame_energy <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            rd_idx <= rd_idx + CNT_W'(1);
            if (rd_idx == LAST_C) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((outstanding == '0) && (fifo_count == '0) && (out_idx == NBINS_C)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
